// File: rtl/rv_bram_fifo.sv
// rv_bram_fifo: ready/valid FIFO backed by an external registered-read dual-port RAM.
// The RAM output register acts as the head slot, so capacity is DEPTH+1.
module rv_bram_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [WIDTH-1:0]             s_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [WIDTH-1:0]             m_data,
    output logic [$clog2(DEPTH+2)-1:0]   count,
    output logic                         ram_wena,
    output logic [$clog2(DEPTH)-1:0]     ram_addra,
    output logic [WIDTH-1:0]             ram_dina,
    output logic                         ram_renb,
    output logic [$clog2(DEPTH)-1:0]     ram_addrb,
    input  logic [WIDTH-1:0]             ram_doutb
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 2);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] ram_cnt;
    logic          push, pop, ren;

    // A read is issued only when the head slot is free or being consumed this cycle.
    always_comb begin
        s_ready   = (ram_cnt < FULL) && !flush;
        push      = s_valid && s_ready;
        ren       = (ram_cnt != '0) && (!m_valid || m_ready) && !flush;
        pop       = m_valid && m_ready;
        ram_wena  = push;
        ram_addra = wr_ptr;
        ram_dina  = s_data;
        ram_renb  = ren;
        ram_addrb = rd_ptr;
        m_data    = ram_doutb;
        count     = ram_cnt + CW'(m_valid);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ram_cnt <= '0;
            m_valid <= 1'b0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ram_cnt <= '0;
            m_valid <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (ren) rd_ptr <= rd_ptr + 1'b1;
            if (push && !ren) ram_cnt <= ram_cnt + 1'b1;
            else if (ren && !push) ram_cnt <= ram_cnt - 1'b1;
            if (ren) m_valid <= 1'b1;
            else if (pop) m_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rv_bram_fifo.sv
// tb_rv_bram_fifo: directed and random checks of rv_bram_fifo (DEPTH=4) against a
// behavioural registered-read RAM and a queue scoreboard.
module tb_rv_bram_fifo;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 2);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [WIDTH-1:0] s_data = '0;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [WIDTH-1:0] m_data;
    logic [CW-1:0]    count;
    logic             ram_wena, ram_renb;
    logic [AW-1:0]    ram_addra, ram_addrb;
    logic [WIDTH-1:0] ram_dina;
    logic [WIDTH-1:0] ram_doutb = '0;
    logic [WIDTH-1:0] mem [DEPTH];

    logic [WIDTH-1:0] q[$];
    logic             stalled = 1'b0;
    logic [WIDTH-1:0] held = '0;
    int               total = 0, passed = 0, failed = 0;

    rv_bram_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .count(count),
        .ram_wena(ram_wena), .ram_addra(ram_addra), .ram_dina(ram_dina),
        .ram_renb(ram_renb), .ram_addrb(ram_addrb), .ram_doutb(ram_doutb)
    );

    always #5 clk = ~clk;

    // Read-during-write yields the old word because both updates are non-blocking.
    always @(posedge clk) begin
        if (ram_renb) ram_doutb <= mem[ram_addrb];
        if (ram_wena) mem[ram_addra] <= ram_dina;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge rst_n) begin
        q.delete();
        stalled = 1'b0;
    end

    // Scoreboard: handshakes seen at negedge take effect on the following rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (flush) begin
                q.delete();
                stalled = 1'b0;
            end else begin
                if (stalled && m_valid) check("stable", m_data, held);
                if (m_valid && m_ready) begin
                    check("pop_nonempty", 32'(q.size() != 0), 32'd1);
                    if (q.size() != 0) check("pop_data", m_data, q.pop_front());
                end
                if (s_valid && s_ready) q.push_back(s_data);
                stalled = m_valid && !m_ready;
                held = m_data;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        m_ready = 1'b1;
        s_valid = 1'b0;
        for (int i = 0; i < 64 && q.size() != 0; i++) @(negedge clk);
        check("drain_empty", q.size(), 0);
        @(negedge clk);
        check("drain_count", count, 0);
        check("drain_mvalid", m_valid, 0);
        tick();
        m_ready = 1'b0;
    endtask

    initial begin
        #12;
        check("rst_mvalid", m_valid, 0);
        check("rst_count", count, 0);
        check("rst_wena", ram_wena, 0);
        check("rst_renb", ram_renb, 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_sready", s_ready, 1);

        // single word latency
        tick();
        s_valid = 1'b1;
        s_data = 32'hA5A5A5A5;
        @(negedge clk);
        check("single_wena", ram_wena, 1);
        tick();
        s_valid = 1'b0;
        @(negedge clk);
        check("single_renb", ram_renb, 1);
        check("single_mvalid_t1", m_valid, 0);
        tick();
        @(negedge clk);
        check("single_mvalid_t2", m_valid, 1);
        check("single_data", m_data, 32'hA5A5A5A5);
        check("single_count", count, 1);
        drain();

        // fill past capacity with consumer stalled
        for (int i = 0; i < 6; i++) begin
            tick();
            s_valid = 1'b1;
            s_data = i;
            @(negedge clk);
            check("fill_sready", s_ready, 32'(i != 5));
        end
        tick();
        s_valid = 1'b0;
        @(negedge clk);
        check("fill_count", count, 5);
        check("fill_q", q.size(), 5);
        drain();

        // streaming across two pointer wraps
        m_ready = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            tick();
            s_valid = (k <= 2 * DEPTH);
            s_data = 32'h1000 + k;
            @(negedge clk);
            check("stream_mvalid", m_valid, 32'(k >= 2));
        end
        drain();

        // random traffic with backpressure
        for (int k = 0; k < 300; k++) begin
            tick();
            s_valid = 1'($urandom_range(0, 1));
            s_data = $urandom;
            m_ready = 1'($urandom_range(0, 2) == 0);
        end
        drain();

        // flush with three words held and a simultaneous push
        for (int i = 0; i < 3; i++) begin
            tick();
            s_valid = 1'b1;
            s_data = 200 + i;
        end
        tick();
        s_valid = 1'b0;
        @(negedge clk);
        check("pre_flush_count", count, 3);
        tick();
        flush = 1'b1;
        s_valid = 1'b1;
        s_data = 32'hDEAD;
        @(negedge clk);
        check("flush_sready", s_ready, 0);
        check("flush_wena", ram_wena, 0);
        check("flush_renb", ram_renb, 0);
        tick();
        flush = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        check("flush_count", count, 0);
        check("flush_mvalid", m_valid, 0);
        tick();
        s_valid = 1'b1;
        s_data = 77;
        tick();
        s_valid = 1'b0;
        drain();

        // asynchronous reset mid-stream
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            s_valid = 1'b1;
            s_data = 300 + i;
        end
        #1;
        check("prereset_mvalid", m_valid, 1);
        #1;
        rst_n = 1'b0;
        s_valid = 1'b0;
        #1;
        check("arst_mvalid", m_valid, 0);
        check("arst_count", count, 0);
        check("arst_renb", ram_renb, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            s_valid = 1'b1;
            s_data = 400 + i;
        end
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
